// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: FSM states, IR opcode field values,
// bus mux selects and the decoded-instruction record.
package cpu_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NUM_REG = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_ADDR = 3'd1,
        ST_FETCH_DATA = 3'd2,
        ST_EXECUTE    = 3'd3,
        ST_OPERAND    = 3'd4,
        ST_HALT       = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_MOV  = 4'h2,
        OP_LDI  = 4'h3,
        OP_JMP  = 4'h4,
        OP_JZ   = 4'h5,
        OP_PUSH = 4'h6,
        OP_POP  = 4'h7,
        OP_HALT = 4'hF
    } op_t;

    localparam logic [2:0] M1_PC   = 3'd4;
    localparam logic [2:0] M1_IR   = 3'd5;
    localparam logic [1:0] M2_ALU  = 2'd0;
    localparam logic [1:0] M2_BUS1 = 2'd1;
    localparam logic [1:0] M2_RAM  = 2'd2;

    // src doubles as the ALU operation field; dst selects the register to load
    typedef struct packed {
        op_t        op;
        logic       legal;
        logic [1:0] src;
        logic [1:0] dst;
    } decode_t;

    function automatic logic [NUM_REG-1:0] reg_onehot(input logic [1:0] idx);
        return NUM_REG'(1) << idx;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit to datapath signal bundle.
interface control_unit_if;
    import cpu_pkg::*;

    logic              run;
    logic [DATA_W-1:0] IR_out;
    logic [DATA_W-1:0] alu_out;
    logic              load_R0, load_R1, load_R2, load_R3;
    logic              inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR;
    logic [1:0]        opcode;
    logic [2:0]        Mux_1_sel;
    logic [1:0]        Mux_2_sel;
    logic              push, pop;
    logic              halted, illegal, zero;

    modport master (
        input  run, IR_out, alu_out,
        output load_R0, load_R1, load_R2, load_R3,
               inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR,
               opcode, Mux_1_sel, Mux_2_sel, push, pop, halted, illegal, zero
    );

    modport slave (
        output run, IR_out, alu_out,
        input  load_R0, load_R1, load_R2, load_R3,
               inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR,
               opcode, Mux_1_sel, Mux_2_sel, push, pop, halted, illegal, zero
    );

endinterface

// File: rtl/instr_decoder.sv
// Splits the instruction register into opcode class and register fields.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output decode_t           dec
);

    always_comb begin
        dec.op    = OP_NOP;
        dec.legal = 1'b1;
        dec.src   = ir[3:2];
        dec.dst   = ir[1:0];
        case (ir[7:4])
            4'h0:    dec.op = OP_NOP;
            4'h1:    dec.op = OP_ALU;
            4'h2:    dec.op = OP_MOV;
            4'h3:    dec.op = OP_LDI;
            4'h4:    dec.op = OP_JMP;
            4'h5:    dec.op = OP_JZ;
            4'h6:    dec.op = OP_PUSH;
            4'h7:    dec.op = OP_POP;
            4'hF:    dec.op = OP_HALT;
            default: dec.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle CPU control FSM: fetch, decode/execute, optional operand cycle.
module control_unit
    import cpu_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.master bus
);

    state_t             state, state_nxt;
    decode_t            dec;
    logic               zero_q, illegal_q;
    logic [NUM_REG-1:0] load_r;

    instr_decoder u_dec (
        .ir  (bus.IR_out),
        .dec (dec)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Z flag tracks the last ALU result; illegal stays set until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (state == ST_EXECUTE) begin
            if (dec.op == OP_ALU && dec.legal) zero_q <= (bus.alu_out == '0);
            if (!dec.legal) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_t boundary;
        boundary  = bus.run ? ST_FETCH_ADDR : ST_IDLE;
        state_nxt = state;
        case (state)
            ST_IDLE:       if (bus.run) state_nxt = ST_FETCH_ADDR;
            ST_FETCH_ADDR: state_nxt = ST_FETCH_DATA;
            ST_FETCH_DATA: state_nxt = ST_EXECUTE;
            ST_EXECUTE: begin
                if (!dec.legal) begin
                    state_nxt = HALT_ON_ILLEGAL ? ST_HALT : boundary;
                end else begin
                    case (dec.op)
                        OP_LDI, OP_JMP: state_nxt = ST_OPERAND;
                        OP_JZ:          state_nxt = zero_q ? ST_OPERAND : boundary;
                        OP_HALT:        state_nxt = ST_HALT;
                        default:        state_nxt = boundary;
                    endcase
                end
            end
            ST_OPERAND:    state_nxt = boundary;
            ST_HALT:       state_nxt = ST_HALT;
            default:       state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        load_r         = '0;
        bus.inc_PC     = 1'b0;
        bus.load_PC    = 1'b0;
        bus.load_Add_R = 1'b0;
        bus.load_Reg_Y = 1'b0;
        bus.load_Reg_Z = 1'b0;
        bus.load_IR    = 1'b0;
        bus.opcode     = 2'd0;
        bus.Mux_1_sel  = 3'd0;
        bus.Mux_2_sel  = 2'd0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.halted     = 1'b0;
        case (state)
            ST_FETCH_ADDR: begin
                bus.Mux_1_sel  = M1_PC;
                bus.Mux_2_sel  = M2_BUS1;
                bus.load_Add_R = 1'b1;
            end
            ST_FETCH_DATA: begin
                bus.Mux_2_sel = M2_RAM;
                bus.load_IR   = 1'b1;
                bus.inc_PC    = 1'b1;
            end
            ST_EXECUTE: begin
                case (dec.op)
                    OP_ALU: begin
                        bus.opcode     = dec.src;
                        bus.Mux_2_sel  = M2_ALU;
                        load_r         = reg_onehot(dec.dst);
                        bus.load_Reg_Z = 1'b1;
                    end
                    OP_MOV: begin
                        bus.Mux_1_sel = {1'b0, dec.src};
                        bus.Mux_2_sel = M2_BUS1;
                        load_r        = reg_onehot(dec.dst);
                    end
                    OP_LDI, OP_JMP: begin
                        bus.Mux_1_sel  = M1_PC;
                        bus.Mux_2_sel  = M2_BUS1;
                        bus.load_Add_R = 1'b1;
                    end
                    OP_JZ: begin
                        // not taken: step PC past the unused operand byte
                        if (zero_q) begin
                            bus.Mux_1_sel  = M1_PC;
                            bus.Mux_2_sel  = M2_BUS1;
                            bus.load_Add_R = 1'b1;
                        end else begin
                            bus.inc_PC = 1'b1;
                        end
                    end
                    OP_PUSH: bus.push = 1'b1;
                    OP_POP:  bus.pop  = 1'b1;
                    default: ;
                endcase
            end
            ST_OPERAND: begin
                bus.Mux_2_sel = M2_RAM;
                if (dec.op == OP_LDI) begin
                    load_r     = reg_onehot(dec.dst);
                    bus.inc_PC = 1'b1;
                end else begin
                    bus.load_PC = 1'b1;
                end
            end
            ST_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.load_R0 = load_r[0];
    assign bus.load_R1 = load_r[1];
    assign bus.load_R2 = load_r[2];
    assign bus.load_R3 = load_r[3];
    assign bus.zero    = zero_q;
    assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed table, random instruction stream, corner sequences.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] ld_r;
        logic       inc_pc, load_pc, load_add_r, load_reg_y, load_reg_z, load_ir;
        logic [1:0] opc;
        logic [2:0] m1;
        logic [1:0] m2;
        logic       push, pop;
    } vec_t;

    typedef struct {
        logic [7:0] ir;
        logic [7:0] alu;
        vec_t       ex;
        vec_t       opd;
        int         cpi;
    } rec_t;

    logic clk, rst;
    int   checks, errors;
    logic mz, mill;

    control_unit_if ifa ();
    control_unit_if ifb ();

    control_unit #(.HALT_ON_ILLEGAL(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    control_unit #(.HALT_ON_ILLEGAL(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] ldr, input logic inc, input logic lpc,
                                input logic ladd, input logic lz, input logic [1:0] opc,
                                input logic [2:0] m1, input logic [1:0] m2,
                                input logic ps, input logic pp);
        vec_t v;
        v = '0;
        v.ld_r = ldr; v.inc_pc = inc; v.load_pc = lpc; v.load_add_r = ladd;
        v.load_reg_z = lz; v.opc = opc; v.m1 = m1; v.m2 = m2; v.push = ps; v.pop = pp;
        return v;
    endfunction

    function automatic vec_t fa_vec();
        return mk(4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4, 2'd1, 1'b0, 1'b0);
    endfunction

    function automatic vec_t fd_vec();
        vec_t v;
        v = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0);
        v.load_ir = 1'b1;
        return v;
    endfunction

    function automatic vec_t cur(input bit sel_b);
        vec_t v;
        if (!sel_b) begin
            v.ld_r = {ifa.load_R3, ifa.load_R2, ifa.load_R1, ifa.load_R0};
            v.inc_pc = ifa.inc_PC; v.load_pc = ifa.load_PC; v.load_add_r = ifa.load_Add_R;
            v.load_reg_y = ifa.load_Reg_Y; v.load_reg_z = ifa.load_Reg_Z; v.load_ir = ifa.load_IR;
            v.opc = ifa.opcode; v.m1 = ifa.Mux_1_sel; v.m2 = ifa.Mux_2_sel;
            v.push = ifa.push; v.pop = ifa.pop;
        end else begin
            v.ld_r = {ifb.load_R3, ifb.load_R2, ifb.load_R1, ifb.load_R0};
            v.inc_pc = ifb.inc_PC; v.load_pc = ifb.load_PC; v.load_add_r = ifb.load_Add_R;
            v.load_reg_y = ifb.load_Reg_Y; v.load_reg_z = ifb.load_Reg_Z; v.load_ir = ifb.load_IR;
            v.opc = ifb.opcode; v.m1 = ifb.Mux_1_sel; v.m2 = ifb.Mux_2_sel;
            v.push = ifb.push; v.pop = ifb.pop;
        end
        return v;
    endfunction

    // Reference: per-instruction cycle behaviour straight from the opcode table
    task automatic ref_instr(input logic [7:0] ir, input logic z,
                             output vec_t ex, output vec_t opd, output int cpi);
        logic [1:0] a;
        logic [3:0] dst;
        a   = ir[3:2];
        dst = 4'b0001 << ir[1:0];
        ex  = '0; opd = '0; cpi = 3;
        case (ir[7:4])
            4'h1: ex = mk(dst, 1'b0, 1'b0, 1'b0, 1'b1, a, 3'd0, 2'd0, 1'b0, 1'b0);
            4'h2: ex = mk(dst, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, {1'b0, a}, 2'd1, 1'b0, 1'b0);
            4'h3: begin
                ex = fa_vec(); cpi = 4;
                opd = mk(dst, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0);
            end
            4'h4, 4'h5: begin
                if (ir[7:4] == 4'h4 || z) begin
                    ex = fa_vec(); cpi = 4;
                    opd = mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0);
                end else begin
                    ex = mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0);
                end
            end
            4'h6: ex = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0);
            4'h7: ex = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1);
            default: ;
        endcase
    endtask

    task automatic chk_vec(input string nm, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic r, input logic [7:0] ir, input logic [7:0] alu);
        ifa.run = r; ifa.IR_out = ir; ifa.alu_out = alu;
        ifb.run = r; ifb.IR_out = ir; ifb.alu_out = alu;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Leaves both DUTs in IDLE, one time unit after a rising edge
    task automatic do_reset();
        step();
        rst = 1'b0;
        set_in(1'b0, 8'h00, 8'h00);
        step();
        rst = 1'b1;
        mz = 1'b0; mill = 1'b0;
    endtask

    // Entered one time unit into a FETCH_ADDR cycle of dut_a
    task automatic run_instr(input logic [7:0] ir, input logic [7:0] alu,
                             input vec_t ex, input vec_t opd, input int cpi, input string nm);
        set_in(1'b1, ir, alu);
        @(negedge clk);
        chk_vec({nm, " fetch_addr"}, cur(1'b0), fa_vec());
        chk_bit({nm, " zero"}, ifa.zero, mz);
        chk_bit({nm, " illegal"}, ifa.illegal, mill);
        chk_bit({nm, " halted"}, ifa.halted, 1'b0);
        step();
        @(negedge clk);
        chk_vec({nm, " fetch_data"}, cur(1'b0), fd_vec());
        step();
        @(negedge clk);
        chk_vec({nm, " execute"}, cur(1'b0), ex);
        if (ir[7:4] == 4'h1) mz = (alu == 8'h00);
        if (ir[7:4] >= 4'h8 && ir[7:4] <= 4'hE) mill = 1'b1;
        step();
        if (cpi == 4) begin
            @(negedge clk);
            chk_vec({nm, " operand"}, cur(1'b0), opd);
            step();
        end
    endtask

    rec_t tbl[12];

    initial begin
        vec_t ex, opd, zv;
        int   cpi, cnt;
        logic [7:0] ir, alu;
        checks = 0; errors = 0;
        zv = '0;
        mz = 1'b0; mill = 1'b0;
        set_in(1'b0, 8'h00, 8'h00);
        rst = 1'b1;

        tbl[0]  = '{8'h00, 8'h55, zv, zv, 3};
        tbl[1]  = '{8'h1D, 8'h00, mk(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 2'd0, 1'b0, 1'b0), zv, 3};
        tbl[2]  = '{8'h51, 8'h11, fa_vec(), mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0), 4};
        tbl[3]  = '{8'h12, 8'h07, mk(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0), zv, 3};
        tbl[4]  = '{8'h51, 8'h00, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0), zv, 3};
        tbl[5]  = '{8'h2B, 8'h00, mk(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd2, 2'd1, 1'b0, 1'b0), zv, 3};
        tbl[6]  = '{8'h33, 8'h00, fa_vec(), mk(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0), 4};
        tbl[7]  = '{8'h40, 8'h00, fa_vec(), mk(4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0), 4};
        tbl[8]  = '{8'h60, 8'h00, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b1, 1'b0), zv, 3};
        tbl[9]  = '{8'h70, 8'h00, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd0, 1'b0, 1'b1), zv, 3};
        tbl[10] = '{8'h92, 8'h00, zv, zv, 3};
        tbl[11] = '{8'h1C, 8'h01, mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 2'd0, 1'b0, 1'b0), zv, 3};

        // Immediate reset response
        #2 rst = 1'b0;
        #1;
        chk_vec("reset strobes", cur(1'b0), zv);
        chk_bit("reset zero", ifa.zero, 1'b0);
        chk_bit("reset illegal", ifa.illegal, 1'b0);
        chk_bit("reset halted", ifa.halted, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk_vec("idle no run", cur(1'b0), zv);

        set_in(1'b1, 8'h00, 8'h00);
        step();
        foreach (tbl[i]) run_instr(tbl[i].ir, tbl[i].alu, tbl[i].ex, tbl[i].opd, tbl[i].cpi, $sformatf("tbl%0d", i));

        // Random stream against the reference model (HALT opcode excluded)
        for (int n = 0; n < 200; n++) begin
            ir  = 8'($urandom_range(0, 255));
            if (ir[7:4] == 4'hF) ir[7:4] = 4'h5;
            alu = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            ref_instr(ir, mz, ex, opd, cpi);
            run_instr(ir, alu, ex, opd, cpi, $sformatf("rnd%0d_ir%h", n, ir));
        end

        // NOP stream: one inc_PC every three cycles
        do_reset();
        set_in(1'b1, 8'h00, 8'h00);
        step();
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ifa.inc_PC) cnt++;
        end
        checks++;
        if (cnt != 10) begin
            errors++;
            $display("FAIL nop inc_pc count: got %0d expected 10", cnt);
        end

        // run dropped during LDI fetch: operand still completes, then idle
        do_reset();
        set_in(1'b1, 8'h31, 8'h00);
        step();
        step();
        set_in(1'b0, 8'h31, 8'h00);
        @(negedge clk);
        chk_vec("ldi stop fetch_data", cur(1'b0), fd_vec());
        step();
        @(negedge clk);
        chk_vec("ldi stop execute", cur(1'b0), fa_vec());
        step();
        @(negedge clk);
        chk_vec("ldi stop operand", cur(1'b0), mk(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 2'd2, 1'b0, 1'b0));
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk_vec($sformatf("ldi stop idle%0d", i), cur(1'b0), zv);
        end

        // Reset in JMP operand cycle after setting Z
        do_reset();
        set_in(1'b1, 8'h10, 8'h00);
        step();
        run_instr(8'h10, 8'h00, mk(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0, 1'b0, 1'b0), zv, 3, "pre_jmp alu");
        set_in(1'b1, 8'h40, 8'h00);
        step();
        step();
        @(negedge clk);
        chk_vec("jmp execute", cur(1'b0), fa_vec());
        chk_bit("jmp zero set", ifa.zero, 1'b1);
        step();
        rst = 1'b0;
        #1;
        chk_vec("jmp reset strobes", cur(1'b0), zv);
        chk_bit("jmp reset zero", ifa.zero, 1'b0);
        @(negedge clk);
        chk_bit("jmp reset load_pc", ifa.load_PC, 1'b0);
        step();
        rst = 1'b1;
        mz = 1'b0; mill = 1'b0;
        step();
        @(negedge clk);
        chk_vec("restart fetch_addr", cur(1'b0), fa_vec());

        // Illegal opcode: dut_b halts, dut_a treats it as NOP
        do_reset();
        set_in(1'b1, 8'h92, 8'h00);
        step();
        step();
        step();
        @(negedge clk);
        chk_bit("ill b pre illegal", ifb.illegal, 1'b0);
        chk_bit("ill b pre halted", ifb.halted, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            chk_bit($sformatf("ill b halted%0d", i), ifb.halted, 1'b1);
            chk_bit($sformatf("ill b illegal%0d", i), ifb.illegal, 1'b1);
            chk_vec($sformatf("ill b strobes%0d", i), cur(1'b1), zv);
        end
        chk_bit("ill a illegal", ifa.illegal, 1'b1);
        chk_bit("ill a halted", ifa.halted, 1'b0);
        step();
        rst = 1'b0;
        #1;
        chk_bit("ill b reset halted", ifb.halted, 1'b0);
        chk_bit("ill b reset illegal", ifb.illegal, 1'b0);
        step();
        rst = 1'b1;

        // HALT opcode: held regardless of run
        do_reset();
        set_in(1'b1, 8'hF0, 8'h00);
        step();
        step();
        step();
        step();
        set_in(1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_bit($sformatf("halt a halted%0d", i), ifa.halted, 1'b1);
            chk_vec($sformatf("halt a strobes%0d", i), cur(1'b0), zv);
            ifa.run = 1'b1; ifb.run = 1'b1;
            step();
        end
        do_reset();
        @(negedge clk);
        chk_bit("halt a cleared", ifa.halted, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 0, meaning: 1 = illegal opcode enters HALT; 0 = illegal opcode executes as NOP.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 run  in  1  level; 1 = fetch/execute, 0 = stop at the next instruction boundary.
REQ-005 IR_out  in  8  instruction register contents from the datapath.
REQ-006 alu_out  in  8  datapath ALU result, used for the zero flag.
REQ-007 load_R0, load_R1, load_R2, load_R3  out  1 each  register load strobes.
REQ-008 inc_PC, load_PC, load_Add_R, load_Reg_Y, load_Reg_Z, load_IR  out  1 each  datapath strobes.
REQ-009 opcode  out  2  ALU operation select.
REQ-010 Mux_1_sel  out  3  Bus_1 source: 0..3 = R0..R3, 4 = PC, 5 = IR.
REQ-011 Mux_2_sel  out  2  Bus_2 source: 0 = ALU, 1 = Bus_1, 2 = data_ram.
REQ-012 push, pop  out  1 each  stack-pointer strobes.
REQ-013 halted  out  1  high while in HALT.
REQ-014 illegal  out  1  sticky; set on decode of an undefined opcode.
REQ-015 zero  out  1  internal Z flag.

Function
REQ-016 States SHALL be IDLE, FETCH_ADDR, FETCH_DATA, EXECUTE, OPERAND, HALT.
REQ-017 IDLE: all strobes low; go to FETCH_ADDR when run=1.
REQ-018 FETCH_ADDR: Mux_1_sel=4, Mux_2_sel=1, load_Add_R=1; next state FETCH_DATA.
REQ-019 FETCH_DATA: Mux_2_sel=2, load_IR=1, inc_PC=1; next state EXECUTE.
REQ-020 EXECUTE decodes IR_out[7:4] as follows:
- 0x0 NOP: no strobes.
- 0x1 ALU: opcode=IR[3:2]; Mux_2_sel=0; load_R<IR[1:0]>=1; load_Reg_Z=1; Z <= (alu_out==0).
- 0x2 MOV: Mux_1_sel=IR[3:2], Mux_2_sel=1, load_R<IR[1:0]>=1.
- 0x3 LDI, 0x4 JMP, 0x5 JZ with Z=1: Mux_1_sel=4, Mux_2_sel=1, load_Add_R=1; next state OPERAND.
- 0x5 JZ with Z=0: inc_PC=1 (skips the operand byte).
- 0x6 PUSH: push=1. 0x7 POP: pop=1.
- 0xF HALT: next state HALT.
- Other values: set illegal; act per HALT_ON_ILLEGAL.
REQ-021 OPERAND: Mux_2_sel=2; LDI asserts load_R<IR[1:0]> and inc_PC; JMP/JZ assert load_PC.
REQ-022 After EXECUTE (single-cycle ops) or OPERAND: go to FETCH_ADDR if run=1, else IDLE.
REQ-023 CPI SHALL be 3 for NOP/ALU/MOV/PUSH/POP/JZ-not-taken and 4 for LDI/JMP/JZ-taken.
REQ-024 inc_PC and load_PC SHALL never be asserted in the same cycle; at most one of load_R0..R3 is high at a time.
REQ-025 push and pop SHALL be single-cycle pulses and never asserted together.
REQ-026 Deasserting run mid-instruction SHALL NOT abort it; the current instruction completes first.
REQ-027 HALT SHALL be exited only by reset; all strobes are low and halted=1 while in HALT.
REQ-028 Strobes and mux selects SHALL be a combinational decode of state, IR_out and Z; unlisted outputs are 0.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, Z=0, illegal=0, halted=0, all strobes 0, opcode=0, Mux_1_sel=0, Mux_2_sel=0.
REQ-030 Reset mid-instruction SHALL abandon the instruction; after release, fetch restarts from the datapath PC.

Structure
REQ-031 The state encoding, IR opcode field values and mux-select constants SHALL live in a shared package, cpu_pkg.
REQ-032 The IR-field decode SHALL be one sub-module, instr_decoder; the FSM stays in control_unit.

Verification
REQ-033 Reset, then run=1 with IR=0x00: FETCH_ADDR, FETCH_DATA, EXECUTE repeat; exactly one inc_PC per 3 cycles.
REQ-034 IR=0x1D (opcode 3, dst R1) with alu_out=0x00: load_R1=1, opcode=3, Mux_2_sel=0, load_Reg_Z=1; zero=1 after the edge.
REQ-035 IR=0x51 with zero=0: inc_PC in EXECUTE, no load_PC, CPI=3; with zero=1: load_PC in OPERAND with Mux_2_sel=2, CPI=4.
REQ-036 IR=0x92 with HALT_ON_ILLEGAL=1: illegal=1 and halted=1, held for 20 cycles; rst=0 clears both.
REQ-037 run dropped during an LDI FETCH_DATA cycle: OPERAND still loads the register, then IDLE with no further strobes.
REQ-038 rst asserted in OPERAND of a JMP: load_PC never asserted; outputs match REQ-029 within the same cycle.
